// File: rtl/stack_burst_engine_if.sv
// Bundle of CPU-side request/response signals and stack RAM lines for stack_burst_engine.
// The slave modport is the engine's view; the master modport is the CPU/RAM side.
interface stack_burst_engine_if #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MAX_WORDS = 16,
  parameter int CNT_W     = 5
);
  localparam int PW = DATA_W * MAX_WORDS;

  logic              start;
  logic              write_mode;
  logic [ADDR_W-1:0] address;
  logic [CNT_W-1:0]  words;
  logic [PW-1:0]     wdata;
  logic [PW-1:0]     rdata;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  modport slave (
    input  start, write_mode, address, words, wdata, ram_q,
    output rdata, busy, done, error, ram_address, ram_data, ram_wren
  );

  modport master (
    output start, write_mode, address, words, wdata, ram_q,
    input  rdata, busy, done, error, ram_address, ram_data, ram_wren
  );
endinterface

// File: rtl/stack_burst_engine.sv
// Burst mover between a packed register vector and a single-port stack RAM.
// Owns the RAM address/data/wren lines; spills (write) and fills (read) N words.
module stack_burst_engine #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MAX_WORDS = 16,
  parameter int CNT_W     = 5
) (
  input  logic                 clock,
  input  logic                 reset_n,
  stack_burst_engine_if.slave  bus
);
  localparam int PW    = DATA_W * MAX_WORDS;
  localparam int IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FINISH} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  idx_reg, idx_next;
  logic [CNT_W-1:0]  words_reg, words_next;
  logic [ADDR_W-1:0] ram_address_reg, ram_address_next;
  logic [DATA_W-1:0] ram_data_reg, ram_data_next;
  logic              ram_wren_reg, ram_wren_next;
  logic              error_reg, error_next;

  logic              busy_w;
  logic              accept;
  logic              capture;
  logic [CNT_W-1:0]  cap_idx;
  logic [DATA_W-1:0] wword [MAX_WORDS];
  logic [PW-1:0]     rdata_vec;

  assign busy_w  = (state_reg == WRITE) || (state_reg == READ) || (state_reg == DRAIN);
  assign accept  = bus.start && !busy_w;

  // idx_reg counts addresses already presented, so the word arriving on ram_q
  // in the current cycle belongs to the address presented two increments ago.
  assign capture = ((state_reg == READ) && (idx_reg >= CNT_W'(2))) || (state_reg == DRAIN);
  assign cap_idx = idx_reg - CNT_W'(2);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      words_reg       <= '0;
      ram_address_reg <= '0;
      ram_data_reg    <= '0;
      ram_wren_reg    <= 1'b0;
      error_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      words_reg       <= words_next;
      ram_address_reg <= ram_address_next;
      ram_data_reg    <= ram_data_next;
      ram_wren_reg    <= ram_wren_next;
      error_reg       <= error_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    words_next       = words_reg;
    ram_address_next = ram_address_reg;
    ram_data_next    = ram_data_reg;
    ram_wren_next    = 1'b0;
    error_next       = 1'b0;
    case (state_reg)
      IDLE, FINISH: begin
        state_next = IDLE;
        if (bus.start) begin
          words_next = bus.words;
          if (bus.words == '0) begin
            state_next = FINISH;
          end else if (bus.words > MAX_CNT) begin
            error_next = 1'b1;
          end else begin
            state_next       = bus.write_mode ? WRITE : READ;
            ram_address_next = bus.address;
            ram_data_next    = bus.wdata[PW-1 -: DATA_W];
            ram_wren_next    = bus.write_mode;
            idx_next         = CNT_W'(1);
          end
        end
      end
      WRITE: begin
        if (idx_reg == words_reg) begin
          state_next = FINISH;
        end else begin
          ram_address_next = ram_address_reg + ADDR_W'(1);
          ram_data_next    = wword[idx_reg[IDX_W-1:0]];
          ram_wren_next    = 1'b1;
          idx_next         = idx_reg + CNT_W'(1);
        end
      end
      READ: begin
        idx_next = idx_reg + CNT_W'(1);
        if (idx_reg == words_reg) begin
          state_next = DRAIN;
        end else begin
          ram_address_next = ram_address_reg + ADDR_W'(1);
        end
      end
      DRAIN: begin
        state_next = FINISH;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAX_WORDS; gi++) begin : gen_word
      logic [DATA_W-1:0] w_word_reg;
      logic [DATA_W-1:0] r_word_reg;

      always_ff @(posedge clock) begin
        if (accept) begin
          w_word_reg <= bus.wdata[PW-1-gi*DATA_W -: DATA_W];
        end
      end

      // Every accepted request, including rejected and zero-length ones, clears the result.
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          r_word_reg <= '0;
        end else if (accept) begin
          r_word_reg <= '0;
        end else if (capture && (cap_idx == CNT_W'(gi))) begin
          r_word_reg <= bus.ram_q;
        end
      end

      assign wword[gi] = w_word_reg;
      assign rdata_vec[PW-1-gi*DATA_W -: DATA_W] = r_word_reg;
    end
  endgenerate

  assign bus.rdata       = rdata_vec;
  assign bus.busy        = busy_w;
  assign bus.done        = (state_reg == FINISH);
  assign bus.error       = error_reg;
  assign bus.ram_address = ram_address_reg;
  assign bus.ram_data    = ram_data_reg;
  assign bus.ram_wren    = ram_wren_reg;
endmodule

// File: tb/tb_stack_burst_engine.sv
// Scoreboard bench for stack_burst_engine: stimulus pushes expected RAM writes and
// done/error pulses with their cycle numbers; a negedge monitor pops and compares.
module tb_stack_burst_engine;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int MAX_WORDS = 16;
  localparam int CNT_W     = 5;
  localparam int PW        = DATA_W * MAX_WORDS;

  localparam int K_WR   = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int          kind;
    int          cyc;
    logic [15:0] addr;
    logic [15:0] data;
    logic [PW-1:0] rd;
  } ev_t;

  logic clock;
  logic reset_n;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  ev_t  exp_q[$];
  logic [15:0] mem [0:65535];

  stack_burst_engine_if #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)
  ) bus ();

  stack_burst_engine #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Stack RAM model: write-enable plus registered read.
  always @(posedge clock) begin
    if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
    bus.ram_q <= mem[bus.ram_address];
  end

  task automatic chk(input string name, input logic [PW-1:0] got, input logic [PW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, want);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      int  kind;
      ev_t e;
      bit  ok;
      if (bus.done && bus.error) begin
        checks++;
        errors++;
        $display("FAIL done_error_exclusive both high at cycle %0d", cyc);
      end
      if (bus.ram_wren || bus.done || bus.error) begin
        kind = bus.ram_wren ? K_WR : (bus.done ? K_DONE : K_ERR);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event kind %0d at cycle %0d addr %h data %h", kind, cyc,
                   bus.ram_address, bus.ram_data);
        end else begin
          e  = exp_q.pop_front();
          ok = (e.kind == kind) && (e.cyc == cyc);
          if (kind == K_WR) ok = ok && (bus.ram_address === e.addr) && (bus.ram_data === e.data);
          else              ok = ok && (bus.rdata === e.rd) && (bus.busy === 1'b0);
          if (!ok) begin
            errors++;
            $display("FAIL event got kind %0d cycle %0d addr %h data %h busy %b rdata %h expected kind %0d cycle %0d addr %h data %h rdata %h",
                     kind, cyc, bus.ram_address, bus.ram_data, bus.busy, bus.rdata,
                     e.kind, e.cyc, e.addr, e.data, e.rd);
          end else begin
            $display("event kind %0d cycle %0d addr %h data %h ok", kind, cyc, bus.ram_address, bus.ram_data);
          end
        end
      end
    end
  end

  task automatic push_ev(input int kind, input int c, input logic [15:0] a,
                         input logic [15:0] d, input logic [PW-1:0] rd);
    ev_t e;
    e.kind = kind; e.cyc = c; e.addr = a; e.data = d; e.rd = rd;
    exp_q.push_back(e);
  endtask

  task automatic issue(input bit wm, input logic [15:0] a, input logic [CNT_W-1:0] n,
                       input logic [PW-1:0] wd, output int t);
    @(posedge clock); #1;
    bus.start      = 1'b1;
    bus.write_mode = wm;
    bus.address    = a;
    bus.words      = n;
    bus.wdata      = wd;
    t = cyc;
  endtask

  task automatic drop(input string name, input logic exp_busy);
    @(posedge clock); #1;
    bus.start = 1'b0;
    chk(name, bus.busy, exp_busy);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout with %0d expected events pending", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clock);
  endtask

  initial begin
    logic [PW-1:0] wd;
    logic [PW-1:0] rd;
    logic [15:0]   w16 [16];
    int t;

    w16 = '{16'h0101, 16'h1212, 16'h2323, 16'h3434, 16'h4545, 16'h5656, 16'h6767, 16'h7878,
            16'h8989, 16'h9A9A, 16'hABAB, 16'hBCBC, 16'hCDCD, 16'hDEDE, 16'hEFEF, 16'hF0F0};
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;

    reset_n = 1'b0;
    bus.start = 1'b0; bus.write_mode = 1'b0; bus.address = '0; bus.words = '0; bus.wdata = '0;
    repeat (3) @(posedge clock); #1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_error", bus.error, 0);
    chk("reset_wren", bus.ram_wren, 0);
    chk("reset_ram_address", bus.ram_address, 0);
    chk("reset_ram_data", bus.ram_data, 0);
    chk("reset_rdata", bus.rdata, 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Write N=3 at 0x0010
    wd = '0;
    wd[PW-1  -: 16] = 16'hA1A1;
    wd[PW-17 -: 16] = 16'hB2B2;
    wd[PW-33 -: 16] = 16'hC3C3;
    wd[15:0]        = 16'hDEAD;
    issue(1'b1, 16'h0010, 5'd3, wd, t);
    push_ev(K_WR, t+1, 16'h0010, 16'hA1A1, '0);
    push_ev(K_WR, t+2, 16'h0011, 16'hB2B2, '0);
    push_ev(K_WR, t+3, 16'h0012, 16'hC3C3, '0);
    push_ev(K_DONE, t+4, 16'h0, 16'h0, '0);
    drop("write3_busy", 1'b1);
    wait_idle("write3", 40);

    // Read N=3 back
    rd = '0;
    rd[PW-1  -: 16] = 16'hA1A1;
    rd[PW-17 -: 16] = 16'hB2B2;
    rd[PW-33 -: 16] = 16'hC3C3;
    issue(1'b0, 16'h0010, 5'd3, '1, t);
    push_ev(K_DONE, t+5, 16'h0, 16'h0, rd);
    drop("read3_busy", 1'b1);
    wait_idle("read3", 40);
    chk("read3_rdata_held", bus.rdata, rd);

    // Write N=16 at 0xFFFE, wrapping through 0x0000
    wd = '0;
    for (int i = 0; i < 16; i++) wd[PW-1-i*16 -: 16] = w16[i];
    issue(1'b1, 16'hFFFE, 5'd16, wd, t);
    for (int i = 0; i < 16; i++) push_ev(K_WR, t+1+i, 16'(16'hFFFE + i), w16[i], '0);
    push_ev(K_DONE, t+17, 16'h0, 16'h0, '0);
    drop("write16_busy", 1'b1);
    wait_idle("write16", 60);

    // Read N=16 back
    issue(1'b0, 16'hFFFE, 5'd16, '0, t);
    push_ev(K_DONE, t+18, 16'h0, 16'h0, wd);
    drop("read16_busy", 1'b1);
    wait_idle("read16", 60);

    // words=17 rejected, rdata cleared
    issue(1'b1, 16'h0400, 5'd17, wd, t);
    push_ev(K_ERR, t+1, 16'h0, 16'h0, '0);
    drop("err17_busy", 1'b0);
    wait_idle("err17", 20);
    chk("err17_no_write", mem[16'h0400], 16'h0000);

    // words=0 completes immediately with no RAM access
    issue(1'b1, 16'h3333, 5'd0, wd, t);
    push_ev(K_DONE, t+1, 16'h0, 16'h0, '0);
    drop("zero_busy", 1'b0);
    wait_idle("zero", 20);
    chk("zero_addr_held", bus.ram_address, 16'h000D);
    chk("zero_no_write", mem[16'h3333], 16'h0000);

    // Reset at T+2 of an N=8 write
    wd = '0;
    for (int i = 0; i < 8; i++) wd[PW-1-i*16 -: 16] = 16'(16'h5000 + i);
    issue(1'b1, 16'h0100, 5'd8, wd, t);
    push_ev(K_WR, t+1, 16'h0100, 16'h5000, '0);
    push_ev(K_WR, t+2, 16'h0101, 16'h5001, '0);
    drop("abort_busy", 1'b1);
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    chk("abort_busy_low", bus.busy, 0);
    chk("abort_wren_low", bus.ram_wren, 0);
    repeat (12) @(posedge clock);
    #1;
    chk("abort_pending", exp_q.size(), 0);
    chk("abort_word1", mem[16'h0101], 16'h5001);
    chk("abort_word2", mem[16'h0102], 16'h0000);
    exp_q.delete();

    // Fresh start after abort
    wd = '0;
    wd[PW-1  -: 16] = 16'h7E57;
    wd[PW-17 -: 16] = 16'h600D;
    issue(1'b1, 16'h0200, 5'd2, wd, t);
    push_ev(K_WR, t+1, 16'h0200, 16'h7E57, '0);
    push_ev(K_WR, t+2, 16'h0201, 16'h600D, '0);
    push_ev(K_DONE, t+3, 16'h0, 16'h0, '0);
    drop("fresh_busy", 1'b1);
    wait_idle("fresh", 30);

    // start held through an N=4 read: one burst, then a second accepted in the done cycle
    rd = '0;
    rd[PW-1  -: 16] = 16'hA1A1;
    rd[PW-17 -: 16] = 16'hB2B2;
    rd[PW-33 -: 16] = 16'hC3C3;
    issue(1'b0, 16'h0010, 5'd4, '0, t);
    push_ev(K_DONE, t+6, 16'h0, 16'h0, rd);
    rd = '0;
    rd[PW-1  -: 16] = 16'hB2B2;
    rd[PW-17 -: 16] = 16'hC3C3;
    push_ev(K_DONE, t+12, 16'h0, 16'h0, rd);
    repeat (5) @(posedge clock);
    #1;
    chk("held_busy_mid", bus.busy, 1);
    @(posedge clock); #1;
    bus.address = 16'h0011;
    chk("held_busy_done_cycle", bus.busy, 0);
    drop("held_second_busy", 1'b1);
    wait_idle("held", 40);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
